mult_error_accum: RTL and testbench

Streaming error-statistics accumulator placed directly downstream of the paired exact (VM_8bit) and approximate (AVM_8bit) 8x8 multipliers. Each accepted sample is one exact/approximate 16-bit product pair. Over a run of N_SAMPLES pairs, the block accumulates absolute-error metrics for the approximate multiplier:

- count of nonzero errors
- maximum absolute error
- sum of absolute errors
- signed error bias

These are the hardware equivalent of the exhaustive software comparison, and they feed error-distance and accuracy figures for the DCT study.

---
 rtl/mult_error_accum.sv | 129 ++++++++++++
 tb/tb_mult_error_accum.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_error_accum.sv
`default_nettype none
// ============================================================================
// Module   : mult_error_accum
// Purpose  : Streaming error statistics for exact vs approximate 8x8 products.
// Revision : 1.0 - initial release
// ============================================================================
module mult_error_accum #(
    parameter int N_SAMPLES = 65536
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] exact,
    input  logic [15:0] approx,
    output logic        busy,
    output logic        done,
    output logic [16:0] sample_cnt,
    output logic [16:0] err_count,
    output logic [15:0] max_err,
    output logic [31:0] sum_err,
    output logic [32:0] bias_sum
);

    localparam logic [1:0]  c_IDLE  = 2'd0;
    localparam logic [1:0]  c_RUN   = 2'd1;
    localparam logic [1:0]  c_DRAIN = 2'd2;
    localparam logic [16:0] c_LAST  = 17'(N_SAMPLES - 1);

    logic [1:0]  r_state;
    logic        r_in_ready;
    logic        r_busy;
    logic        r_done;
    logic [16:0] r_sample_cnt;
    logic [16:0] r_err_count;
    logic [15:0] r_max_err;
    logic [31:0] r_sum_err;
    logic [32:0] r_bias_sum;
    logic        r_s1_valid;
    logic [15:0] r_s1_abs;
    logic [16:0] r_s1_diff;

    logic        w_xfer;
    logic [16:0] w_diff;
    logic [16:0] w_neg;
    logic [15:0] w_abs;

    // 17-bit difference never wraps; its magnitude always fits in 16 bits.
    assign w_xfer = in_valid & r_in_ready;
    assign w_diff = {1'b0, exact} - {1'b0, approx};
    assign w_neg  = 17'd0 - w_diff;
    assign w_abs  = w_diff[16] ? w_neg[15:0] : w_diff[15:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_IDLE;
            r_in_ready   <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_sample_cnt <= '0;
            r_err_count  <= '0;
            r_max_err    <= '0;
            r_sum_err    <= '0;
            r_bias_sum   <= '0;
            r_s1_valid   <= 1'b0;
            r_s1_abs     <= '0;
            r_s1_diff    <= '0;
        end else begin
            r_done     <= 1'b0;
            r_s1_valid <= w_xfer;
            if (w_xfer) begin
                r_s1_abs     <= w_abs;
                r_s1_diff    <= w_diff;
                r_sample_cnt <= r_sample_cnt + 17'd1;
            end
            if (r_s1_valid) begin
                r_sum_err   <= r_sum_err + {16'd0, r_s1_abs};
                r_bias_sum  <= r_bias_sum + {{16{r_s1_diff[16]}}, r_s1_diff};
                r_err_count <= r_err_count + {16'd0, (r_s1_abs != 16'd0)};
                if (r_s1_abs > r_max_err) begin
                    r_max_err <= r_s1_abs;
                end
            end
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_state      <= c_RUN;
                        r_in_ready   <= 1'b1;
                        r_busy       <= 1'b1;
                        r_sample_cnt <= '0;
                        r_err_count  <= '0;
                        r_max_err    <= '0;
                        r_sum_err    <= '0;
                        r_bias_sum   <= '0;
                        r_s1_valid   <= 1'b0;
                    end
                end
                c_RUN: begin
                    if (w_xfer && (r_sample_cnt == c_LAST)) begin
                        r_state    <= c_DRAIN;
                        r_in_ready <= 1'b0;
                    end
                end
                c_DRAIN: begin
                    r_state <= c_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
                default: begin
                    r_state    <= c_IDLE;
                    r_in_ready <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign busy       = r_busy;
    assign done       = r_done;
    assign sample_cnt = r_sample_cnt;
    assign err_count  = r_err_count;
    assign max_err    = r_max_err;
    assign sum_err    = r_sum_err;
    assign bias_sum   = r_bias_sum;

endmodule
`default_nettype wire

// File: tb/tb_mult_error_accum.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_error_accum
// Purpose  : Directed scoreboard bench for mult_error_accum (N=4 and N=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mult_error_accum;

    typedef struct {
        logic [16:0] cnt;
        logic [16:0] errc;
        logic [15:0] maxe;
        logic [31:0] sum;
        logic [32:0] bias;
    } stats_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start4 = 1'b0;
    logic        start2 = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] exact = '0;
    logic [15:0] approx = '0;

    logic        rdy4, busy4, done4, rdy2, busy2, done2;
    logic [16:0] cnt4, errc4, cnt2, errc2;
    logic [15:0] maxe4, maxe2;
    logic [31:0] sum4, sum2;
    logic [32:0] bias4, bias2;

    int checks = 0;
    int failures = 0;
    stats_t sb_q[$];
    logic [15:0] pe[4];
    logic [15:0] pa[4];

    always #5 clk = ~clk;

    mult_error_accum #(.N_SAMPLES(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .in_valid(in_valid), .in_ready(rdy4),
        .exact(exact), .approx(approx), .busy(busy4), .done(done4),
        .sample_cnt(cnt4), .err_count(errc4), .max_err(maxe4), .sum_err(sum4),
        .bias_sum(bias4)
    );

    mult_error_accum #(.N_SAMPLES(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .in_valid(in_valid), .in_ready(rdy2),
        .exact(exact), .approx(approx), .busy(busy2), .done(done2),
        .sample_cnt(cnt2), .err_count(errc2), .max_err(maxe2), .sum_err(sum2),
        .bias_sum(bias2)
    );

    // Output view of whichever instance the current step targets.
    logic        sel2 = 1'b0;
    logic        o_rdy, o_busy, o_done;
    logic [16:0] o_cnt, o_errc;
    logic [15:0] o_maxe;
    logic [31:0] o_sum;
    logic [32:0] o_bias;
    always_comb begin
        o_rdy  = sel2 ? rdy2  : rdy4;
        o_busy = sel2 ? busy2 : busy4;
        o_done = sel2 ? done2 : done4;
        o_cnt  = sel2 ? cnt2  : cnt4;
        o_errc = sel2 ? errc2 : errc4;
        o_maxe = sel2 ? maxe2 : maxe4;
        o_sum  = sel2 ? sum2  : sum4;
        o_bias = sel2 ? bias2 : bias4;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic stats_t model(input int n);
        stats_t s;
        longint bias = 0;
        longint sum = 0;
        int d, a, mx = 0, ec = 0;
        for (int i = 0; i < n; i++) begin
            d = int'(pe[i]) - int'(pa[i]);
            a = (d < 0) ? -d : d;
            bias += longint'(d);
            sum += longint'(a);
            if (a != 0) ec++;
            if (a > mx) mx = a;
        end
        s.cnt  = 17'(n);
        s.errc = 17'(ec);
        s.maxe = 16'(mx);
        s.sum  = 32'(sum);
        s.bias = 33'(bias);
        return s;
    endfunction

    task automatic check_stats(input string tag, input stats_t e);
        chk({tag, "_cnt"},  64'(o_cnt),  64'(e.cnt));
        chk({tag, "_errc"}, 64'(o_errc), 64'(e.errc));
        chk({tag, "_max"},  64'(o_maxe), 64'(e.maxe));
        chk({tag, "_sum"},  64'(o_sum),  64'(e.sum));
        chk({tag, "_bias"}, 64'(o_bias), 64'(e.bias));
    endtask

    task automatic check_zero(input string tag);
        stats_t z;
        z.cnt = '0; z.errc = '0; z.maxe = '0; z.sum = '0; z.bias = '0;
        check_stats(tag, z);
    endtask

    // One full run: optional start, n pairs (optionally gapped), drain/done checks,
    // and optionally a start in the done cycle that launches the next run.
    task automatic run(input string tag, input bit use2, input int n, input bit skip_start,
                       input bit gaps, input bit start_mid, input bit chain);
        stats_t e;
        sel2 = use2;
        if (!skip_start) begin
            if (use2) start2 = 1'b1; else start4 = 1'b1;
            step();
            start2 = 1'b0; start4 = 1'b0;
            chk({tag, "_rdy_after_start"}, 64'(o_rdy), 64'd1);
            chk({tag, "_busy_after_start"}, 64'(o_busy), 64'd1);
            chk({tag, "_cleared_sum"}, 64'(o_sum), 64'd0);
        end
        sb_q.push_back(model(n));
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                in_valid = 1'b0;
                exact = 16'($urandom);
                approx = 16'($urandom);
                step();
                chk({tag, "_gap_cnt"}, 64'(o_cnt), 64'(i));
            end
            in_valid = 1'b1;
            exact = pe[i];
            approx = pa[i];
            if (start_mid && i == 1) begin
                if (use2) start2 = 1'b1; else start4 = 1'b1;
            end
            step();
            start2 = 1'b0; start4 = 1'b0;
            chk({tag, "_cnt_step"}, 64'(o_cnt), 64'(i + 1));
        end
        in_valid = 1'b0;
        exact = 16'hdead;
        approx = 16'hbeef;
        chk({tag, "_rdy_fall"}, 64'(o_rdy), 64'd0);
        chk({tag, "_busy_drain"}, 64'(o_busy), 64'd1);
        chk({tag, "_done_early"}, 64'(o_done), 64'd0);
        step();
        chk({tag, "_done"}, 64'(o_done), 64'd1);
        chk({tag, "_busy_done"}, 64'(o_busy), 64'd0);
        chk({tag, "_sb_nonempty"}, 64'(sb_q.size() != 0), 64'd1);
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check_stats(tag, e);
        end
        if (chain) begin
            if (use2) start2 = 1'b1; else start4 = 1'b1;
        end
        step();
        start2 = 1'b0; start4 = 1'b0;
        chk({tag, "_done_clear"}, 64'(o_done), 64'd0);
        if (chain) begin
            chk({tag, "_chain_rdy"}, 64'(o_rdy), 64'd1);
            chk({tag, "_chain_cleared_cnt"}, 64'(o_cnt), 64'd0);
            chk({tag, "_chain_cleared_sum"}, 64'(o_sum), 64'd0);
            chk({tag, "_chain_cleared_max"}, 64'(o_maxe), 64'd0);
        end else begin
            chk({tag, "_hold_sum"}, 64'(o_sum), 64'(e.sum));
        end
    endtask

    task automatic load_basic();
        pe[0] = 16'd100;   pa[0] = 16'd100;
        pe[1] = 16'd200;   pa[1] = 16'd190;
        pe[2] = 16'd50;    pa[2] = 16'd60;
        pe[3] = 16'd65025; pa[3] = 16'd64000;
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        sel2 = 1'b0;
        chk("reset_rdy4", 64'(rdy4), 64'd0);
        chk("reset_busy4", 64'(busy4), 64'd0);
        chk("reset_done4", 64'(done4), 64'd0);
        chk("reset_rdy2", 64'(rdy2), 64'd0);
        check_zero("reset");

        // Basic run with a start in the done cycle, then a gapped run with start abuse
        load_basic();
        run("basic", 1'b0, 4, 1'b0, 1'b0, 1'b0, 1'b1);
        run("gaps", 1'b0, 4, 1'b1, 1'b1, 1'b1, 1'b0);

        // Negative / no-wrap on the N=2 instance
        pe[0] = 16'd0;     pa[0] = 16'd65535;
        pe[1] = 16'd65535; pa[1] = 16'd0;
        run("nowrap", 1'b1, 2, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset after 2 of 4 pairs, with start asserted alongside rst
        load_basic();
        sel2 = 1'b0;
        start4 = 1'b1;
        step();
        start4 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            exact = pe[i];
            approx = pa[i + 1];
            step();
        end
        chk("midrun_cnt", 64'(cnt4), 64'd2);
        rst = 1'b1;
        start4 = 1'b1;
        step();
        chk("rst_done", 64'(done4), 64'd0);
        step();
        rst = 1'b0;
        start4 = 1'b0;
        in_valid = 1'b0;
        chk("rst_mid_rdy", 64'(rdy4), 64'd0);
        chk("rst_mid_busy", 64'(busy4), 64'd0);
        chk("rst_mid_done", 64'(done4), 64'd0);
        check_zero("rst_mid");
        step();
        chk("post_rst_idle_rdy", 64'(rdy4), 64'd0);
        chk("post_rst_no_done", 64'(done4), 64'd0);
        run("fresh", 1'b0, 4, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
